// File: rtl/at_rx.sv
// at_rx: receive-side AT response parser for the Wi-Fi/MQTT module UART link.
// Flags OK/ERROR result lines and frames +MQTTSUBRECV payloads as a byte stream.
module at_rx #(
  parameter int MAX_LEN     = 1024,
  parameter int LEN_W       = 11,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             resp_ok,
  output logic             resp_error,
  output logic [7:0]       sub_data,
  output logic             sub_valid,
  output logic             sub_first,
  output logic             sub_last,
  output logic [LEN_W-1:0] sub_len,
  output logic             sub_err,
  output logic             busy
);
  localparam int ACC_W  = LEN_W + 4;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [ACC_W-1:0]  MAX_ACC   = ACC_W'(MAX_LEN);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  localparam logic [8*4-1:0]  STR_OK  = "OK\r\n";
  localparam logic [8*7-1:0]  STR_ERR = "ERROR\r\n";
  localparam logic [8*13-1:0] STR_SUB = "+MQTTSUBRECV:";

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_QUOTE = 8'h22;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_PLUS  = 8'h2B;

  typedef enum logic [3:0] {
    LINE_START, MATCH_OK, MATCH_ERR, MATCH_SUB, SKIP_LINE, SUB_LINK,
    SUB_TQ, SUB_TOPIC, SUB_TC, SUB_LEN, SUB_DATA, SUB_EOL
  } state_e;

  // Expected character at position i of the keyword being matched in st.
  function automatic logic [7:0] match_char(input state_e st, input logic [3:0] i);
    logic [7:0] c;
    c = 8'h00;
    case (st)
      MATCH_OK:  c = STR_OK[8*(3 - int'(i)) +: 8];
      MATCH_ERR: c = STR_ERR[8*(6 - int'(i)) +: 8];
      MATCH_SUB: c = STR_SUB[8*(12 - int'(i)) +: 8];
      default:   c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] match_last(input state_e st);
    case (st)
      MATCH_OK:  return 4'd3;
      MATCH_ERR: return 4'd6;
      default:   return 4'd12;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               dig_q, dig_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               resp_ok_q, resp_ok_d, resp_error_q, resp_error_d;
  logic [7:0]         sub_data_q, sub_data_d;
  logic               sub_valid_q, sub_valid_d, sub_first_q, sub_first_d;
  logic               sub_last_q, sub_last_d, sub_err_q, sub_err_d, busy_q, busy_d;
  logic [LEN_W-1:0]   sub_len_q, sub_len_d;

  logic [ACC_W+3:0]   acc_wide;
  logic [ACC_W-1:0]   acc_sat;
  logic               is_digit, len_ok, in_sub, hdr_err;

  // acc*10 + digit, computed 4 bits wider so overflow can be detected and clamped.
  assign acc_wide = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                  + {{ACC_W{1'b0}}, rx_data[3:0]};
  assign acc_sat  = (|acc_wide[ACC_W+3:ACC_W]) ? '1 : acc_wide[ACC_W-1:0];
  assign is_digit = (rx_data >= CH_0) && (rx_data <= CH_9);
  assign len_ok   = dig_q && (acc_q != '0) && (acc_q <= MAX_ACC);
  assign in_sub   = state_q inside {SUB_LINK, SUB_TQ, SUB_TOPIC, SUB_TC, SUB_LEN, SUB_DATA};

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case leaves it unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    dig_d        = dig_q;
    rem_d        = rem_q;
    idle_d       = idle_q;
    sub_data_d   = sub_data_q;
    sub_len_d    = sub_len_q;
    resp_ok_d    = 1'b0;
    resp_error_d = 1'b0;
    sub_valid_d  = 1'b0;
    sub_first_d  = 1'b0;
    sub_last_d   = 1'b0;
    sub_err_d    = 1'b0;
    hdr_err      = 1'b0;

    if (rx_valid) begin
      idle_d = '0;
      case (state_q)
        LINE_START: begin
          idx_d = 4'd1;
          if (rx_data == CH_O)                          state_d = MATCH_OK;
          else if (rx_data == CH_E)                     state_d = MATCH_ERR;
          else if (rx_data == CH_PLUS)                  state_d = MATCH_SUB;
          else if (rx_data != CH_CR && rx_data != CH_LF) state_d = SKIP_LINE;
        end
        MATCH_OK, MATCH_ERR, MATCH_SUB: begin
          if (rx_data != match_char(state_q, idx_q)) begin
            state_d = (rx_data == CH_LF) ? LINE_START : SKIP_LINE;
          end else if (idx_q != match_last(state_q)) begin
            idx_d = idx_q + 4'd1;
          end else begin
            resp_ok_d    = (state_q == MATCH_OK);
            resp_error_d = (state_q == MATCH_ERR);
            state_d      = (state_q == MATCH_SUB) ? SUB_LINK : LINE_START;
          end
        end
        SKIP_LINE, SUB_EOL: if (rx_data == CH_LF) state_d = LINE_START;
        SUB_LINK:  if (rx_data == CH_COMMA) state_d = SUB_TQ;
        SUB_TQ:    if (rx_data == CH_QUOTE) state_d = SUB_TOPIC; else hdr_err = 1'b1;
        SUB_TOPIC: if (rx_data == CH_QUOTE) state_d = SUB_TC;
        SUB_TC: begin
          if (rx_data == CH_COMMA) begin
            state_d = SUB_LEN;
            acc_d   = '0;
            dig_d   = 1'b0;
          end else begin
            hdr_err = 1'b1;
          end
        end
        SUB_LEN: begin
          if (is_digit) begin
            acc_d = acc_sat;
            dig_d = 1'b1;
          end else if (rx_data == CH_COMMA && len_ok) begin
            sub_len_d = acc_q[LEN_W-1:0];
            rem_d     = acc_q[LEN_W-1:0];
            state_d   = SUB_DATA;
          end else begin
            hdr_err = 1'b1;
          end
        end
        SUB_DATA: begin
          sub_valid_d = 1'b1;
          sub_data_d  = rx_data;
          sub_first_d = (rem_q == sub_len_q);
          sub_last_d  = (rem_q == LEN_W'(1));
          rem_d       = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = SUB_EOL;
        end
        default: state_d = LINE_START;
      endcase
      if (hdr_err) begin
        sub_err_d = 1'b1;
        state_d   = (rx_data == CH_LF) ? LINE_START : SKIP_LINE;
      end
    end else if (state_q != LINE_START) begin
      // A stalled partial line is abandoned; only an open message reports it.
      if (idle_q == IDLE_LAST) begin
        state_d   = LINE_START;
        idle_d    = '0;
        sub_err_d = in_sub;
      end else if (idle_q != '1) begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end else begin
      idle_d = '0;
    end

    busy_d = (state_d != LINE_START);
  end

  // NOTE: state uses non-blocking assignments with an asynchronous active-low reset clearing every flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LINE_START;
      idx_q        <= '0;
      acc_q        <= '0;
      dig_q        <= 1'b0;
      rem_q        <= '0;
      idle_q       <= '0;
      resp_ok_q    <= 1'b0;
      resp_error_q <= 1'b0;
      sub_data_q   <= '0;
      sub_valid_q  <= 1'b0;
      sub_first_q  <= 1'b0;
      sub_last_q   <= 1'b0;
      sub_len_q    <= '0;
      sub_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      dig_q        <= dig_d;
      rem_q        <= rem_d;
      idle_q       <= idle_d;
      resp_ok_q    <= resp_ok_d;
      resp_error_q <= resp_error_d;
      sub_data_q   <= sub_data_d;
      sub_valid_q  <= sub_valid_d;
      sub_first_q  <= sub_first_d;
      sub_last_q   <= sub_last_d;
      sub_len_q    <= sub_len_d;
      sub_err_q    <= sub_err_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_ok    = resp_ok_q;
  assign resp_error = resp_error_q;
  assign sub_data   = sub_data_q;
  assign sub_valid  = sub_valid_q;
  assign sub_first  = sub_first_q;
  assign sub_last   = sub_last_q;
  assign sub_len    = sub_len_q;
  assign sub_err    = sub_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_at_rx.sv
// tb_at_rx: random and directed stimulus for at_rx, checked every cycle against a
// line-buffer model that re-parses the current header text from scratch on each byte.
`timescale 1ns/1ps
module tb_at_rx;
  localparam int MAX_LEN = 1024;
  localparam int LEN_W   = 11;
  localparam int TO      = 40;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_QUOTE = 8'h22;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam string S_OK  = "OK\r\n";
  localparam string S_ERR = "ERROR\r\n";
  localparam string S_SUB = "+MQTTSUBRECV:";

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             resp_ok, resp_error, sub_valid, sub_first, sub_last, sub_err, busy;
  logic [7:0]       sub_data;
  logic [LEN_W-1:0] sub_len;

  at_rx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .resp_ok(resp_ok), .resp_error(resp_error), .sub_data(sub_data),
    .sub_valid(sub_valid), .sub_first(sub_first), .sub_last(sub_last),
    .sub_len(sub_len), .sub_err(sub_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string qt();
    return $sformatf("%c", CH_QUOTE);
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {M_HDR, M_SKIP, M_PAY, M_EOL} mmode_e;
  mmode_e     mmode = M_HDR;
  logic [7:0] hbuf[$];
  int         rem = 0, mlen = 0, gap = 0;
  logic       e_ok = 0, e_err = 0, e_sv = 0, e_first = 0, e_last = 0, e_suberr = 0, e_busy = 0;
  logic [7:0] e_data = 0;
  int         e_len = 0;

  // need_full: buffer must start with all of s; otherwise buffer must be a prefix of s.
  function automatic bit hbuf_match(input string s, input bit need_full);
    int n, m;
    n = hbuf.size();
    if (need_full ? (n < s.len()) : (n > s.len())) return 1'b0;
    m = (n < s.len()) ? n : s.len();
    for (int i = 0; i < m; i++) if (hbuf[i] != 8'(s[i])) return 1'b0;
    return 1'b1;
  endfunction

  // 0 = incomplete, 1 = malformed, 2 = complete with length len.
  function automatic int parse_hdr(output int len);
    int i, n, nd;
    longint v;
    n = hbuf.size(); i = S_SUB.len(); len = 0; v = 0; nd = 0;
    while (i < n && hbuf[i] != CH_COMMA) i++;
    if (i >= n - 1) return 0;
    i++;
    if (hbuf[i] != CH_QUOTE) return 1;
    i++;
    while (i < n && hbuf[i] != CH_QUOTE) i++;
    if (i >= n - 1) return 0;
    i++;
    if (hbuf[i] != CH_COMMA) return 1;
    i++;
    while (i < n) begin
      if (hbuf[i] >= CH_0 && hbuf[i] <= CH_9) begin
        v = v * 10 + longint'(hbuf[i] - CH_0);
        if (v > 100000) v = 100000;
        nd++;
      end else if (hbuf[i] == CH_COMMA) begin
        if (nd == 0 || v < 1 || v > MAX_LEN) return 1;
        len = int'(v);
        return 2;
      end else begin
        return 1;
      end
      i++;
    end
    return 0;
  endfunction

  function automatic bit m_busy();
    return !(mmode == M_HDR && hbuf.size() == 0);
  endfunction

  task automatic end_line(input logic [7:0] b);
    hbuf.delete();
    mmode = (b == CH_LF) ? M_HDR : M_SKIP;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int st, l;
    case (mmode)
      M_PAY: begin
        e_sv = 1; e_data = b;
        e_first = (rem == mlen); e_last = (rem == 1);
        rem--;
        if (rem == 0) mmode = M_EOL;
      end
      M_SKIP, M_EOL: if (b == CH_LF) mmode = M_HDR;
      default: begin
        if (hbuf.size() == 0 && (b == CH_CR || b == CH_LF)) return;
        hbuf.push_back(b);
        if (hbuf_match(S_SUB, 1'b1)) begin
          st = parse_hdr(l);
          if (st == 1) begin
            e_suberr = 1; end_line(b);
          end else if (st == 2) begin
            mlen = l; rem = l; e_len = l; hbuf.delete(); mmode = M_PAY;
          end
        end else if (hbuf_match(S_OK, 1'b0)) begin
          if (hbuf.size() == S_OK.len()) begin e_ok = 1; hbuf.delete(); end
        end else if (hbuf_match(S_ERR, 1'b0)) begin
          if (hbuf.size() == S_ERR.len()) begin e_err = 1; hbuf.delete(); end
        end else if (!hbuf_match(S_SUB, 1'b0)) begin
          end_line(b);
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmode = M_HDR; hbuf.delete(); rem = 0; mlen = 0; gap = 0;
      e_ok = 0; e_err = 0; e_sv = 0; e_first = 0; e_last = 0; e_suberr = 0; e_busy = 0;
      e_data = 0; e_len = 0;
    end else begin
      e_ok = 0; e_err = 0; e_sv = 0; e_first = 0; e_last = 0; e_suberr = 0;
      if (rx_valid) begin
        gap = 0;
        model_byte(rx_data);
      end else if (m_busy()) begin
        if (gap == TO - 1) begin
          if (mmode == M_PAY || (mmode == M_HDR && hbuf_match(S_SUB, 1'b1))) e_suberr = 1;
          hbuf.delete(); mmode = M_HDR; gap = 0;
        end else begin
          gap++;
        end
      end else begin
        gap = 0;
      end
      e_busy = m_busy();
    end
  end

  // ---------------- compare and observation ----------------
  logic [7:0] cap[$];
  int n_ok = 0, n_err = 0, n_suberr = 0, n_first = 0, n_last = 0, n_fl = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("resp_ok", resp_ok, e_ok);
      check("resp_error", resp_error, e_err);
      check("sub_valid", sub_valid, e_sv);
      check("sub_err", sub_err, e_suberr);
      check("busy", busy, e_busy);
      check("sub_len", sub_len, e_len);
      if (e_sv) begin
        check("sub_data", sub_data, e_data);
        check("sub_first", sub_first, e_first);
        check("sub_last", sub_last, e_last);
      end
      if (sub_valid) begin
        cap.push_back(sub_data);
        if (sub_first) n_first++;
        if (sub_last) n_last++;
        if (sub_first && sub_last) n_fl++;
      end
      if (resp_ok) n_ok++;
      if (resp_error) n_err++;
      if (sub_err) n_suberr++;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] txq[$];

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) txq.push_back(8'(s[i]));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  function automatic int rand_gap();
    int r;
    r = int'($urandom_range(0, 399));
    if (r < 300) return 0;
    if (r < 396) return int'($urandom_range(1, 3));
    return int'($urandom_range(TO - 2, TO + 1));
  endfunction

  task automatic flush(input bit gaps);
    while (txq.size() > 0) begin
      send_byte(txq.pop_front());
      if (gaps) idle(rand_gap());
    end
  endtask

  task automatic push_hdr(input string len_field);
    push_str({"+MQTTSUBRECV:0,", qt(), "t", qt(), ",", len_field, ","});
  endtask

  task automatic gen_sub();
    int n, sel;
    string lf;
    logic [7:0] c;
    sel = int'($urandom_range(0, 9));
    n   = int'($urandom_range(1, 24));
    case (sel)
      0:       lf = "0";
      1:       lf = "";
      2:       lf = "1025";
      3:       lf = "987654321";
      4:       lf = {$sformatf("%0d", n), "q"};
      default: lf = $sformatf("%0d", n);
    endcase
    push_str({$sformatf("+MQTTSUBRECV:%0d,", $urandom_range(0, 4)), qt()});
    repeat ($urandom_range(0, 8)) begin
      c = 8'($urandom_range(32, 126));
      if (c == CH_QUOTE) c = CH_COMMA;
      txq.push_back(c);
    end
    push_str({qt(), ",", lf, ","});
    repeat (n) txq.push_back(8'($urandom));
    push_str("\r\n");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_ok, b_err, b_se, b_cap, b_first, b_last, b_fl;
    string pl;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_resp_ok", resp_ok, 0);
    check("rst_resp_error", resp_error, 0);
    check("rst_sub_valid", sub_valid, 0);
    check("rst_sub_data", sub_data, 0);
    check("rst_sub_len", sub_len, 0);
    check("rst_sub_err", sub_err, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // OK / ERROR / OKX with one-cycle latency
    b_ok = n_ok; b_err = n_err;
    push_str("OK\r"); flush(0);
    send_byte(CH_LF);
    @(posedge clk); #1 check("ok_latency", resp_ok, 1);
    @(posedge clk); #1 check("ok_one_cycle", resp_ok, 0);
    push_str("ERROR\r"); flush(0);
    send_byte(CH_LF);
    @(posedge clk); #1 check("err_latency", resp_error, 1);
    push_str("OKX\r\n"); flush(0); idle(3);
    check("ok_count", n_ok - b_ok, 1);
    check("err_count", n_err - b_err, 1);

    // Payload containing CR, LF and a topic with commas
    b_cap = cap.size(); b_first = n_first; b_last = n_last; b_ok = n_ok;
    push_str({"+MQTTSUBRECV:0,", qt(), "a,b/c", qt(), ",5,he\r\nX\r\n"}); flush(0); idle(3);
    pl = "he\r\nX";
    check("p5_count", cap.size() - b_cap, 5);
    for (int i = 0; i < 5; i++)
      if (cap.size() > b_cap + i) check("p5_byte", cap[b_cap + i], 8'(pl[i]));
    check("p5_len", sub_len, 5);
    check("p5_first", n_first - b_first, 1);
    check("p5_last", n_last - b_last, 1);
    check("p5_no_resp", n_ok - b_ok, 0);

    // Length boundaries 1, MAX_LEN, MAX_LEN+1
    b_cap = cap.size(); b_fl = n_fl;
    push_hdr("1"); push_str("Z\r\n"); flush(0); idle(2);
    check("len1_count", cap.size() - b_cap, 1);
    check("len1_first_last", n_fl - b_fl, 1);
    b_cap = cap.size(); b_last = n_last;
    push_hdr("1024");
    repeat (1024) txq.push_back(8'($urandom));
    push_str("\r\n"); flush(0); idle(2);
    check("len1024_count", cap.size() - b_cap, 1024);
    check("len1024_last", n_last - b_last, 1);
    check("len1024_len", sub_len, 1024);
    b_cap = cap.size(); b_se = n_suberr; b_ok = n_ok;
    push_hdr("1025"); push_str("abc\r\nOK\r\n"); flush(0); idle(2);
    check("len1025_err", n_suberr - b_se, 1);
    check("len1025_no_data", cap.size() - b_cap, 0);
    check("len1025_ok_after", n_ok - b_ok, 1);

    // Malformed length fields, including one terminated by LF
    b_se = n_suberr; b_ok = n_ok;
    push_hdr("1x"); push_str("\r\n");
    push_hdr("0"); push_str("\r\n");
    push_hdr(""); push_str("\r\n");
    push_str({"+MQTTSUBRECV:0,", qt(), "t", qt(), ",12\nOK\r\n"});
    flush(0); idle(2);
    check("badlen_errs", n_suberr - b_se, 4);
    check("badlen_recover", n_ok - b_ok, 1);

    // Timeout mid-payload, then a byte arriving exactly at the threshold
    b_se = n_suberr; b_last = n_last; b_ok = n_ok;
    push_hdr("10"); push_str("abc"); flush(0);
    idle(TO + 3);
    check("to_err", n_suberr - b_se, 1);
    check("to_no_last", n_last - b_last, 0);
    check("to_busy", busy, 0);
    push_str("OK\r\n"); flush(0); idle(2);
    check("to_ok_after", n_ok - b_ok, 1);
    b_se = n_suberr; b_cap = cap.size();
    push_hdr("3"); push_str("p"); flush(0);
    idle(TO - 1);
    push_str("qr\r\n"); flush(0); idle(2);
    check("edge_no_err", n_suberr - b_se, 0);
    check("edge_count", cap.size() - b_cap, 3);

    // Reset in the middle of a payload
    push_hdr("8"); push_str("wxyz"); flush(0);
    @(posedge clk); #1 check("pre_rst_valid", sub_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", sub_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_len", sub_len, 0);
    check("mid_rst_data", sub_data, 0);
    check("mid_rst_err", sub_err, 0);
    idle(2);
    rst_n = 1'b1;
    b_cap = cap.size(); b_se = n_suberr;
    push_hdr("4"); push_str("abcd\r\n"); flush(0); idle(2);
    pl = "abcd";
    check("post_rst_count", cap.size() - b_cap, 4);
    for (int i = 0; i < 4; i++)
      if (cap.size() > b_cap + i) check("post_rst_byte", cap[b_cap + i], 8'(pl[i]));
    check("post_rst_no_err", n_suberr - b_se, 0);

    // Randomised traffic against the model
    for (int k = 0; k < 250; k++) begin
      int kind, n;
      kind = int'($urandom_range(0, 5));
      case (kind)
        0: push_str("OK\r\n");
        1: push_str("ERROR\r\n");
        2, 3: gen_sub();
        4: begin
          n = int'($urandom_range(1, 12));
          repeat (n) txq.push_back(8'($urandom_range(32, 126)));
          push_str("\r\n");
        end
        default: begin
          case ($urandom_range(0, 3))
            0: push_str("OKK\r\n");
            1: push_str("ERRR\r\n");
            2: push_str("+MQTX\r\n");
            default: push_str("\r\nE\n");
          endcase
        end
      endcase
      flush(1);
    end
    idle(TO + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/at_rx.md
# at_rx

Receive-side AT response parser for the UART link to the Wi-Fi/MQTT module. Consumes the byte stream from the UART receiver, recognises the module's `OK` and `ERROR` result lines, and extracts the payload of `+MQTTSUBRECV` downlink messages as a framed byte stream. It sits between the UART RX core and the command sequencer, which uses the result pulses to pace the at_tx publish traffic.

## Interface
- MAX_LEN, 1024, largest accepted payload length in bytes
- LEN_W, 11, width of sub_len; must satisfy 2^LEN_W > MAX_LEN
- TIMEOUT_CYC, 5_000_000, idle clocks allowed mid-line before the partial line is abandoned

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- resp_ok  out  1  one-cycle pulse: complete `OK\r\n` line received
- resp_error  out  1  one-cycle pulse: complete `ERROR\r\n` line received
- sub_data  out  8  payload byte
- sub_valid  out  1  one-cycle strobe qualifying sub_data
- sub_first  out  1  with sub_valid, marks first payload byte
- sub_last  out  1  with sub_valid, marks last payload byte
- sub_len  out  LEN_W  declared payload length; stable from the first payload byte until the next header
- sub_err  out  1  one-cycle pulse: malformed header, bad length, or timeout inside a message
- busy  out  1  high whenever state is not LINE_START

## Operation
- The parser is line-oriented. Every byte is processed only on rx_valid.
- LINE_START: `\r` and `\n` are ignored. `O` goes to MATCH_OK. `E` goes to MATCH_ERR. `+` goes to MATCH_SUB. Any other byte goes to SKIP_LINE.
- MATCH_OK, MATCH_ERR and MATCH_SUB use an index counter against the fixed strings `OK\r\n`, `ERROR\r\n` and `+MQTTSUBRECV:`.
  - On a mismatch, a `\n` goes to LINE_START and any other byte goes to SKIP_LINE.
  - The `\n` completing `OK\r\n` pulses resp_ok. The `\n` completing `ERROR\r\n` pulses resp_error. Either returns to LINE_START.
  - The `:` completing `+MQTTSUBRECV:` goes to SUB_LINK.
- SKIP_LINE: discard bytes until `\n`, then go to LINE_START.
- SUB_LINK: skip bytes until `,`, then go to SUB_TQ.
- SUB_TQ: the byte must be `"`, which goes to SUB_TOPIC. Any other byte is an error.
- SUB_TOPIC: skip bytes until the closing `"`; commas inside the topic are ignored. Then go to SUB_TC.
- SUB_TC: the byte must be `,`, which goes to SUB_LEN. Any other byte is an error.
- SUB_LEN: on entry the length accumulator is 0.
  - Each `0`–`9` updates acc = acc*10 + digit, saturating at all-ones in a LEN_W+4-bit register.
  - `,` ends the field. If acc is in 1..MAX_LEN, load sub_len and the remaining-byte counter, then go to SUB_DATA. Otherwise it is an error.
  - Any other byte, or `,` with no digits, is an error.
- SUB_DATA: every byte, including `\r`, `\n` and `"`, is emitted on sub_data/sub_valid.
  - sub_first is set on byte 1 and sub_last on byte sub_len.
  - After the last byte, go to SUB_EOL.
- SUB_EOL: skip bytes until `\n`, then go to LINE_START. No output is produced.
- Error handling: pulse sub_err. A `\n` error byte goes to LINE_START; any other error byte goes to SKIP_LINE.
- Timeout: the idle counter clears on every rx_valid and counts while busy. On reaching TIMEOUT_CYC-1 the parser returns to LINE_START.
  - If the timeout fires in any SUB_* state except SUB_EOL, pulse sub_err.
  - sub_last is never issued for a truncated payload. Downstream discards the frame on sub_err.

## Timing
- All outputs are registered. Each response appears on the clock edge after the edge that sampled rx_valid, giving 1-cycle latency.
- Pulse outputs are high for exactly one cycle.
- Back-to-back rx_valid on every cycle is supported with no lost bytes.
- Reset values:
  - All outputs are 0: resp_ok, resp_error, sub_data, sub_valid, sub_first, sub_last, sub_len, sub_err, busy.
  - State is LINE_START and all counters are 0.
- Reset mid-message aborts immediately. Outputs go to 0 and no sub_err is produced.
- rx_valid in the same cycle as the timeout threshold: the byte wins. The counter clears and the byte is processed normally.
- sub_len = 1: sub_first and sub_last are asserted together on the same byte.
- sub_len = MAX_LEN is accepted. MAX_LEN+1 is an error.
- The idle counter saturates and does not wrap.

## Test plan
- Send `OK\r\n`, then `ERROR\r\n`, then `OKX\r\n` -> one resp_ok, then one resp_error, each 1 cycle after its `\n`. `OKX\r\n` produces no pulse.
- Send `+MQTTSUBRECV:0,"a,b/c",5,he\r\nX\r\n` -> sub_len=5. Bytes `h e \r \n X` are emitted, with sub_first on `h` and sub_last on `X`. No resp pulses.
- Send a header with length 1, then length 1024, then length 1025 -> length 1 gives one byte with first and last together. Length 1024 gives 1024 bytes. Length 1025 gives a sub_err pulse with no sub_valid, and the following `OK\r\n` still gives resp_ok.
- Send a header with length `1x`, then `0`, then an empty length field -> one sub_err for each, and the parser recovers after `\n`.
- Stop the stream after 3 of 10 payload bytes for TIMEOUT_CYC cycles -> sub_err fires, no sub_last, busy drops, and the next `OK\r\n` is recognised.
- Assert rst_n low in the middle of SUB_DATA -> all outputs go to 0 immediately. After release, a full message parses correctly.
